pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Responder to the processor control unit's flow and stack commands. It owns the program counter and a shared LIFO that holds both data words and return addresses.
- It executes fetch, branch, jmp/call, ret, push and pop strobes, and reports occupancy and error status back to the control unit.

Parameters:
- ADDR_W, 10, program counter width in bits.
- DATA_W, 16, stack word width in bits.
- DEPTH, 16, number of stack entries; must be at least 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- soft_clr  in  1  synchronous clear, driven from the control unit's reset_cu.
- stall  in  1  freezes PC and stack for the cycle.
- fetch  in  1  advance PC by 1.
- branch  in  1  redirect PC to target.
- jmp  in  1  call: push return address, then redirect; asserted together with branch and push.
- ret  in  1  return: pop return address into PC; asserted together with branch and pop.
- push  in  1  push push_data; ignored as data when jmp=1.
- pop  in  1  pop into pop_data; ignored as data when ret=1.
- target  in  ADDR_W  branch/jmp destination.
- push_data  in  DATA_W  data word to push.
- pc  out  ADDR_W  current program counter.
- pop_data  out  DATA_W  last popped data word.
- pop_valid  out  1  one-cycle pulse, the cycle after a successful data pop.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  clog2(DEPTH+1)  number of occupied entries.
- overflow  out  1  sticky: push or jmp attempted while full.
- underflow  out  1  sticky: pop or ret attempted while empty.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-operation) forces:
  - pc=0, count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0;
  - hence empty=1, full=0.
- Stack memory contents are not reset.
- soft_clr=1 applies the same values at the clock edge and has top priority over every other input.
- stall=1:
  - no PC, count or memory update;
  - pop_valid=0;
  - sticky flags hold.
- Command priority per cycle, highest first: soft_clr, stall, ret, jmp, branch, push/pop, fetch. Only the highest active command executes.
- ret:
  - Non-empty: pc <= mem[count-1][ADDR_W-1:0]; count <= count-1; pop_valid stays 0.
  - Empty: underflow <= 1; pc and count unchanged.
- jmp:
  - Not full: mem[count] <= zero-extend(pc+1); count <= count+1; pc <= target.
  - Full: overflow <= 1; pc and count unchanged; the call is dropped.
- branch (without jmp/ret): pc <= target; no stack activity.
- push only:
  - Not full: mem[count] <= push_data; count <= count+1.
  - Full: overflow <= 1; nothing written.
- pop only:
  - Non-empty: pop_data <= mem[count-1]; count <= count-1; pop_valid=1 in the next cycle. Latency is 1 cycle.
  - Empty: underflow <= 1; pop_data holds; no pulse.
- push and pop together (no jmp/ret) with count>0 (replace-top):
  - pop_data <= old top; mem[count-1] <= push_data; count unchanged; pop_valid pulses.
- push and pop together with count=0: behaves as push only; no underflow.
- A fetch in the same cycle as any higher command is ignored.
- fetch alone: pc <= pc+1, modulo 2^ADDR_W (0x3FF wraps to 0x000).
- pc+1 for a jmp return address also wraps modulo 2^ADDR_W.
- pop_valid is 0 in every cycle not immediately following a successful data pop.
- full, empty and count are combinational from the count register.
- overflow and underflow clear only on reset or soft_clr.

Test Plan:
- Reset release, then 3 fetch cycles -> pc 0,1,2,3; empty=1; count=0; flags 0. Pull reset low mid-sequence -> pc=0 immediately, without waiting for a clock edge.
- pc=0x005, jmp+branch+push with target=0x100 -> pc=0x100, count=1. Then ret+branch+pop -> pc=0x006, count=0, pop_valid stays 0.
- DEPTH=4: push 0xA1,0xA2,0xA3,0xA4 -> full=1. Fifth push 0xA5 -> overflow=1, count=4. Pop four times -> pop_data 0xA4,0xA3,0xA2,0xA1, each with a one-cycle pop_valid pulse.
- Empty stack: pop -> underflow=1, pop_valid=0. Then ret -> pc unchanged. Then soft_clr -> underflow=0.
- Stack [0x11,0x22]: push 0x33 and pop together -> pop_data=0x22, top=0x33, count=2. stall=1 with fetch and push -> pc and count unchanged.
- pc=0x3FF, fetch -> pc=0x000. pc=0x3FF, jmp to 0x010 -> stacked value 0x0000. Subsequent ret -> pc=0x000.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter plus shared data/return-address LIFO driven by control-unit strobes.
// Pop data is available 1 cycle after the strobe. There is no backpressure: stall freezes the state, and a push or pop that cannot complete only sets a sticky flag.
module pc_stack_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       soft_clr,
    input  logic                       stall,
    input  logic                       fetch,
    input  logic                       branch,
    input  logic                       jmp,
    input  logic                       ret,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          target,
    input  logic [DATA_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          pc,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       pop_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              is_full, is_empty;
    logic [IDX_W-1:0]  top_idx, wr_idx;
    logic [DATA_W-1:0] top_dat;
    logic [ADDR_W-1:0] pc_inc;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);
    assign top_idx  = IDX_W'(count_q - CNT_W'(1));
    assign wr_idx   = IDX_W'(count_q);
    assign top_dat  = mem_q[top_idx];
    assign pc_inc   = pc_q + ADDR_W'(1);

    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_idx;
        mem_wdata   = push_data;

        if (soft_clr) begin
            pc_d        = '0;
            count_d     = '0;
            pop_data_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                pc_d    = ADDR_W'(top_dat);
                count_d = count_q - CNT_W'(1);
            end
        end else if (jmp) begin
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_wdata = DATA_W'(pc_inc);
                count_d   = count_q + CNT_W'(1);
                pc_d      = target;
            end
        end else if (branch) begin
            pc_d = target;
        end else if (push && pop && !is_empty) begin
            // Replace-top: old top goes out while the new word takes its slot.
            pop_data_d  = top_dat;
            pop_valid_d = 1'b1;
            mem_we      = 1'b1;
            mem_waddr   = top_idx;
        end else if (push) begin
            if (is_full) begin
                overflow_d = 1'b1;
            end else begin
                mem_we  = 1'b1;
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                underflow_d = 1'b1;
            end else begin
                pop_data_d  = top_dat;
                pop_valid_d = 1'b1;
                count_d     = count_q - CNT_W'(1);
            end
        end else if (fetch) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= '0;
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Stack storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign pc        = pc_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed strobes, with popped data checked by a decoupled scoreboard monitor.
module tb_pc_stack_unit;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          reset;
    logic          soft_clr, stall, fetch, branch, jmp, ret, push, pop;
    logic [AW-1:0] target;
    logic [DW-1:0] push_data;
    logic [AW-1:0] pc;
    logic [DW-1:0] pop_data;
    logic          pop_valid, full, empty, overflow, underflow;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];

    pc_stack_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .soft_clr(soft_clr), .stall(stall),
        .fetch(fetch), .branch(branch), .jmp(jmp), .ret(ret),
        .push(push), .pop(pop), .target(target), .push_data(push_data),
        .pc(pc), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
        .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every pop_valid pulse must match the oldest expected pop.
    always @(negedge clk) begin
        if (reset === 1'b1 && pop_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("pop_valid_unexpected", 32'(pop_valid), 32'd0);
            end else begin
                chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic clr_cmds();
        soft_clr = 0; stall = 0; fetch = 0; branch = 0;
        jmp = 0; ret = 0; push = 0; pop = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr_cmds();
    endtask

    task automatic t_fetch();
        fetch = 1; cyc();
    endtask

    task automatic t_push(input logic [DW-1:0] d);
        push = 1; push_data = d; cyc();
    endtask

    task automatic t_pop(input logic [DW-1:0] e);
        pop = 1; exp_q.push_back(e); cyc();
    endtask

    task automatic t_call(input logic [AW-1:0] t);
        jmp = 1; branch = 1; push = 1; target = t; cyc();
    endtask

    task automatic t_ret();
        ret = 1; branch = 1; pop = 1; cyc();
    endtask

    task automatic t_branch(input logic [AW-1:0] t);
        branch = 1; fetch = 1; target = t; cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        clr_cmds();
        target = '0;
        push_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        reset = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            t_fetch();
            chk("fetch_pc", 32'(pc), 32'(i));
        end
        t_fetch(); t_fetch();
        chk("fetch_pc5", 32'(pc), 32'h5);

        reset = 1'b0;
        #2;
        chk("async_rst_pc", 32'(pc), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) t_fetch();
        chk("refetch_pc", 32'(pc), 32'h5);

        t_call(10'h100);
        chk("call_pc", 32'(pc), 32'h100);
        chk("call_count", 32'(count), 32'd1);
        t_ret();
        chk("ret_pc", 32'(pc), 32'h6);
        chk("ret_count", 32'(count), 32'd0);

        t_push(16'hA1); t_push(16'hA2); t_push(16'hA3); t_push(16'hA4);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_full", 32'(full), 32'd1);
        t_push(16'hA5);
        chk("push_full_ovf", 32'(overflow), 32'd1);
        chk("push_full_count", 32'(count), 32'd4);
        t_call(10'h200);
        chk("call_full_pc", 32'(pc), 32'h6);
        chk("call_full_count", 32'(count), 32'd4);
        t_pop(16'hA4); t_pop(16'hA3); t_pop(16'hA2);
        chk("pop3_count", 32'(count), 32'd1);
        t_pop(16'hA1);
        chk("pop4_empty", 32'(empty), 32'd1);

        t_pop(16'h0000);
        void'(exp_q.pop_back());
        chk("pop_empty_unf", 32'(underflow), 32'd1);
        chk("pop_empty_data_hold", 32'(pop_data), 32'hA1);
        t_ret();
        chk("ret_empty_pc", 32'(pc), 32'h6);
        chk("ret_empty_count", 32'(count), 32'd0);
        soft_clr = 1; fetch = 1; cyc();
        chk("soft_clr_pc", 32'(pc), 32'h0);
        chk("soft_clr_flags", {30'd0, overflow, underflow}, 32'd0);
        chk("soft_clr_pop_data", 32'(pop_data), 32'h0);

        t_push(16'h11); t_push(16'h22);
        push = 1; pop = 1; push_data = 16'h33; exp_q.push_back(16'h22); cyc();
        chk("replace_count", 32'(count), 32'd2);
        stall = 1; fetch = 1; push = 1; push_data = 16'h44; cyc();
        chk("stall_pc", 32'(pc), 32'h0);
        chk("stall_count", 32'(count), 32'd2);
        t_pop(16'h33); t_pop(16'h11);
        chk("drain_count", 32'(count), 32'd0);

        t_branch(10'h3FF);
        chk("branch_pc", 32'(pc), 32'h3FF);
        t_fetch();
        chk("wrap_fetch_pc", 32'(pc), 32'h0);
        t_branch(10'h3FF);
        t_call(10'h010);
        chk("wrap_call_pc", 32'(pc), 32'h010);
        t_ret();
        chk("wrap_ret_pc", 32'(pc), 32'h0);
        t_branch(10'h3FF);
        t_call(10'h010);
        t_pop(16'h0000);
        chk("wrap_pop_count", 32'(count), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
